// File: rtl/apb_master_fsm_pkg.sv
// Shared types and width helpers for the APB master front end and its address decoder.
package apb_master_fsm_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

    // Index field keeps at least one bit so a single-slave build still checks it.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        if (w < 8)  w = 8;
        if (w > 32) w = 32;
        return w;
    endfunction

endpackage

// File: rtl/apb_master_fsm_if.sv
// Request/response handshake plus per-slave APB bus between the master FSM and its environment.
interface apb_master_fsm_if #(
    parameter int unsigned SLAVE_COUNT = 3,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    logic                                  req_valid_i;
    logic                                  req_ready_o;
    logic [ADDR_WIDTH-1:0]                 req_addr_i;
    logic                                  req_write_i;
    logic [DATA_WIDTH-1:0]                 req_wdata_i;
    logic                                  rsp_valid_o;
    logic                                  rsp_ready_i;
    logic [DATA_WIDTH-1:0]                 rsp_rdata_o;
    logic                                  rsp_err_o;
    logic [ADDR_WIDTH-1:0]                 ms_paddr_o;
    logic                                  ms_pwrite_o;
    logic [DATA_WIDTH-1:0]                 ms_pwdata_o;
    logic [SLAVE_COUNT-1:0]                ms_psel_o;
    logic                                  ms_penable_o;
    logic [SLAVE_COUNT-1:0][DATA_WIDTH-1:0] ms_prdata_i;
    logic [SLAVE_COUNT-1:0]                ms_pready_i;
    logic [SLAVE_COUNT-1:0]                ms_pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        input  ms_prdata_i, ms_pready_i, ms_pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output ms_paddr_o, ms_pwrite_o, ms_pwdata_o, ms_psel_o, ms_penable_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        output ms_prdata_i, ms_pready_i, ms_pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  ms_paddr_o, ms_pwrite_o, ms_pwdata_o, ms_psel_o, ms_penable_o
    );

endinterface

// File: rtl/apb_master_fsm_addr_decode.sv
// Combinational address decoder: slave index field -> index, one-hot select and decode error.
module apb_master_fsm_addr_decode
    import apb_master_fsm_pkg::*;
#(
    parameter int unsigned SLAVE_COUNT = 3,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned REGION_LSB  = 12,
    localparam int unsigned IDX_W      = idx_width(SLAVE_COUNT)
) (
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic [IDX_W-1:0]       o_idx,
    output logic [SLAVE_COUNT-1:0] o_sel,
    output logic                   o_dec_err
);

    logic w_unused;

    assign o_idx     = i_addr[REGION_LSB +: IDX_W];
    assign o_dec_err = {1'b0, o_idx} >= (IDX_W + 1)'(SLAVE_COUNT);
    assign o_sel     = o_dec_err ? '0 : (SLAVE_COUNT'(1) << o_idx);

    // Address bits outside the index field are deliberately ignored.
    assign w_unused  = ^i_addr;

endmodule

// File: rtl/apb_master_fsm.sv
// Single-outstanding APB master: valid/ready request -> SETUP/ACCESS -> valid/ready response.
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_fsm
    import apb_master_fsm_pkg::*;
#(
    parameter int unsigned SLAVE_COUNT    = 3,
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned REGION_LSB     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    apb_master_fsm_if.master bus
);

    localparam int unsigned IDX_W = idx_width(SLAVE_COUNT);

    apb_state_e             r_state;
    apb_req_t               r_req;
    apb_rsp_t               r_rsp;
    logic [SLAVE_COUNT-1:0] r_psel;
    logic                   r_penable;
    logic                   r_req_ready;
    logic                   r_rsp_valid;

    logic [IDX_W-1:0]       w_idx;
    logic [SLAVE_COUNT-1:0] w_sel;
    logic                   w_dec_err;
    logic                   w_pready;
    logic                   w_pslverr;
    logic [DATA_WIDTH-1:0]  w_prdata;
    logic                   w_timeout;
    logic                   w_unused;

    apb_master_fsm_addr_decode #(
        .SLAVE_COUNT (SLAVE_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .REGION_LSB  (REGION_LSB)
    ) u_decode (
        .i_addr    (bus.req_addr_i),
        .o_idx     (w_idx),
        .o_sel     (w_sel),
        .o_dec_err (w_dec_err)
    );

    // The registered one-hot select picks the addressed slave's return signals.
    assign w_pready  = |(bus.ms_pready_i & r_psel);
    assign w_pslverr = |(bus.ms_pslverr_i & r_psel);

    always_comb begin
        w_prdata = '0;
        for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
            if (r_psel[i]) w_prdata = w_prdata | bus.ms_prdata_i[i];
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_cnt <= '0;
        end else if (r_state == ACCESS && !w_pready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_unused = ^{w_idx, 32'(TIMEOUT_CYCLES)};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_rsp       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        r_req.addr  <= APB_ADDR_W'(bus.req_addr_i);
                        r_req.write <= bus.req_write_i;
                        r_req.wdata <= APB_DATA_W'(bus.req_wdata_i);
                        r_req_ready <= 1'b0;
                        if (w_dec_err) begin
                            // Unmapped address: answer directly without touching the bus.
                            r_state     <= RESP;
                            r_rsp       <= '{rdata: '0, err: 1'b1};
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                            r_psel  <= w_sel;
                        end
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (w_pready) begin
                        r_state     <= RESP;
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp.err   <= w_pslverr;
                        r_rsp.rdata <= (r_req.write || w_pslverr) ? '0 : APB_DATA_W'(w_prdata);
                    end else if (w_timeout) begin
                        r_state     <= RESP;
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp       <= '{rdata: '0, err: 1'b1};
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = r_req_ready;
    assign bus.rsp_valid_o  = r_rsp_valid;
    assign bus.rsp_rdata_o  = DATA_WIDTH'(r_rsp.rdata);
    assign bus.rsp_err_o    = r_rsp.err;
    assign bus.ms_paddr_o   = ADDR_WIDTH'(r_req.addr);
    assign bus.ms_pwrite_o  = r_req.write;
    assign bus.ms_pwdata_o  = DATA_WIDTH'(r_req.wdata);
    assign bus.ms_psel_o    = r_psel;
    assign bus.ms_penable_o = r_penable;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm with three slaves driven as fixed per-step vectors.
module tb_apb_master_fsm;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    apb_master_fsm_if #(.SLAVE_COUNT(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    apb_master_fsm #(
        .SLAVE_COUNT    (3),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .REGION_LSB     (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_addr_i  = addr;
        bus_if.req_write_i = wr;
        bus_if.req_wdata_i = wdata;
        tick();
        bus_if.req_valid_i = 1'b0;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        checks = 0;
        errors = 0;
        bus_if.req_valid_i  = 1'b0;
        bus_if.req_addr_i   = '0;
        bus_if.req_write_i  = 1'b0;
        bus_if.req_wdata_i  = '0;
        bus_if.rsp_ready_i  = 1'b0;
        bus_if.ms_prdata_i[0] = 32'h1111_1111;
        bus_if.ms_prdata_i[1] = 32'hDEAD_BEEF;
        bus_if.ms_prdata_i[2] = 32'h2222_2222;
        bus_if.ms_pready_i  = 3'b111;
        bus_if.ms_pslverr_i = 3'b000;

        // Reset values
        tick();
        tick();
        check("rst_req_ready", 64'(bus_if.req_ready_o), 64'(1'b1));
        check("rst_outputs", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.ms_psel_o,
                                   bus_if.ms_penable_o, bus_if.ms_pwrite_o}), 64'(0));
        check("rst_data", 64'({bus_if.ms_paddr_o, bus_if.rsp_rdata_o}), 64'(0));
        rst = 1'b0;
        tick();

        // Read slave 1, zero wait states
        request(32'h0000_1004, 1'b0, 32'h0);
        check("rd_setup_psel", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o}), 64'(4'b0100));
        check("rd_setup_ready", 64'({bus_if.req_ready_o, bus_if.rsp_valid_o}), 64'(2'b00));
        check("rd_paddr", 64'(bus_if.ms_paddr_o), 64'(32'h0000_1004));
        tick();
        check("rd_access", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o}), 64'(4'b0101));
        check("rd_access_rspv", 64'(bus_if.rsp_valid_o), 64'(1'b0));
        tick();
        check("rd_resp_valid", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o}), 64'(2'b10));
        check("rd_resp_rdata", 64'(bus_if.rsp_rdata_o), 64'(32'hDEAD_BEEF));
        check("rd_resp_bus", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o}), 64'(0));
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        check("rd_idle", 64'({bus_if.req_ready_o, bus_if.rsp_valid_o}), 64'(2'b10));

        // Write slave 2 with 3 wait states; other slaves' ready/err must be ignored
        bus_if.ms_pready_i  = 3'b011;
        bus_if.ms_pslverr_i = 3'b011;
        request(32'h0000_2008, 1'b1, 32'h1234_5678);
        check("wr_setup", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o, bus_if.ms_pwrite_o}), 64'(5'b10001));
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wr_wait_bus", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o, bus_if.rsp_valid_o}),
                  64'(5'b10010));
            check("wr_wait_addr_data", 64'({bus_if.ms_paddr_o, bus_if.ms_pwdata_o}),
                  64'({32'h0000_2008, 32'h1234_5678}));
            tick();
        end
        bus_if.ms_pready_i = 3'b111;
        check("wr_access4", 64'({bus_if.ms_penable_o, bus_if.rsp_valid_o}), 64'(2'b10));
        tick();
        check("wr_resp", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o}), 64'(2'b10));
        check("wr_resp_rdata", 64'(bus_if.rsp_rdata_o), 64'(0));
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i  = 1'b0;
        bus_if.ms_pslverr_i = 3'b000;

        // Decode error: index 3 with three slaves
        request(32'h0000_3000, 1'b0, 32'h0);
        check("dec_resp", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o}), 64'(2'b11));
        check("dec_rdata", 64'(bus_if.rsp_rdata_o), 64'(0));
        check("dec_no_psel", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o}), 64'(0));
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;

        // Slave error from slave 0, response held under back-pressure
        bus_if.ms_pslverr_i = 3'b001;
        request(32'h0000_0010, 1'b0, 32'h0);
        check("serr_setup", 64'(bus_if.ms_psel_o), 64'(3'b001));
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("serr_hold", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.req_ready_o}),
                  64'(3'b110));
            check("serr_rdata", 64'(bus_if.rsp_rdata_o), 64'(0));
            tick();
        end
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i  = 1'b0;
        bus_if.ms_pslverr_i = 3'b000;

        // Asynchronous reset during ACCESS
        bus_if.ms_pready_i = 3'b000;
        request(32'h0000_1000, 1'b0, 32'h0);
        tick();
        check("arst_in_access", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o}), 64'(4'b0101));
        #2 rst = 1'b1;
        #1;
        check("arst_async", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o, bus_if.rsp_valid_o}), 64'(0));
        check("arst_ready", 64'(bus_if.req_ready_o), 64'(1'b1));
        tick();
        rst = 1'b0;
        tick();
        bus_if.ms_pready_i    = 3'b111;
        bus_if.ms_prdata_i[1] = 32'hCAFE_F00D;
        request(32'h0000_1000, 1'b0, 32'h0);
        tick();
        tick();
        check("post_rst_resp", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o}), 64'(2'b10));
        check("post_rst_rdata", 64'(bus_if.rsp_rdata_o), 64'(32'hCAFE_F00D));
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;

        // Slave 2 never ready
        bus_if.ms_pready_i = 3'b011;
        request(32'h0000_2000, 1'b0, 32'h0);
        tick();
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("tmo_waiting", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o, bus_if.rsp_valid_o}),
                  64'(5'b10010));
        end
        tick();
        check("tmo_resp", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o}), 64'(2'b11));
        check("tmo_bus_drop", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o}), 64'(0));
        check("tmo_rdata", 64'(bus_if.rsp_rdata_o), 64'(0));
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
`else
        repeat (100) tick();
        check("nto_still_access", 64'({bus_if.ms_psel_o, bus_if.ms_penable_o, bus_if.rsp_valid_o}),
              64'(5'b10010));
        bus_if.ms_pready_i = 3'b111;
        tick();
        check("nto_resp", 64'({bus_if.rsp_valid_o, bus_if.rsp_err_o}), 64'(2'b10));
        check("nto_rdata", 64'(bus_if.rsp_rdata_o), 64'(32'h2222_2222));
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
`endif
        check("end_idle", 64'({bus_if.req_ready_o, bus_if.rsp_valid_o}), 64'(2'b10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
